// File: rtl/arashi_cache_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arashi_cache_pkg
// Brief    : Shared types and helpers for the per-thread buffering cache.
// Revision : 1.0 - initial release
// ============================================================================
package arashi_cache_pkg;

    typedef enum logic {RD_SELECT = 1'b0, RD_RR = 1'b1} rd_mode_t;

    localparam int c_DEFAULT_TID_WIDTH = 2;

    // Thread id for the default four-thread configuration
    typedef logic [c_DEFAULT_TID_WIDTH-1:0] tid_t;

    // Occupancy counter must represent 0..DEPTH inclusive
    function automatic int count_width(input int depth_width);
        return depth_width + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arashi_cache_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : arashi_cache_arb_if
// Brief    : Producer/consumer bus of the per-thread buffering cache.
// Revision : 1.0 - initial release
// ============================================================================
interface arashi_cache_arb_if #(
    parameter int DATA_WIDTH       = 32,
    parameter int THREAD_NUM_WIDTH = 2
);
    localparam int c_THREAD_NUM = 1 << THREAD_NUM_WIDTH;

    logic [c_THREAD_NUM-1:0]            w_ena;
    logic [DATA_WIDTH*c_THREAD_NUM-1:0] data_in;
    logic                               rcache;
    logic                               mode;
    logic [THREAD_NUM_WIDTH-1:0]        toread;
    logic                               clear_err;
    logic [DATA_WIDTH-1:0]              data_out;
    logic                               out_valid;
    logic [THREAD_NUM_WIDTH-1:0]        out_tid;
    logic [c_THREAD_NUM-1:0]            avail;
    logic [c_THREAD_NUM-1:0]            full;
    logic [c_THREAD_NUM-1:0]            overflow;
    logic                               rd_err;

    modport master (
        output w_ena, data_in, rcache, mode, toread, clear_err,
        input  data_out, out_valid, out_tid, avail, full, overflow, rd_err
    );

    modport slave (
        input  w_ena, data_in, rcache, mode, toread, clear_err,
        output data_out, out_valid, out_tid, avail, full, overflow, rd_err
    );

endinterface
`default_nettype wire

// File: rtl/arashi_cache_arb_thread_fifo.sv
`default_nettype none
// ============================================================================
// Module   : arashi_thread_fifo
// Brief    : Single-thread FIFO with registered avail/full and drop strobe.
// Revision : 1.0 - initial release
// ============================================================================
module arashi_thread_fifo
    import arashi_cache_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WIDTH = 2
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_push,
    input  wire logic                  i_pop,
    input  wire logic [DATA_WIDTH-1:0] i_din,
    output logic      [DATA_WIDTH-1:0] o_head,
    output logic                       o_avail,
    output logic                       o_full,
    output logic                       o_push_drop
);
    localparam int c_DEPTH = 1 << DEPTH_WIDTH;
    localparam int c_CNT_W = count_width(DEPTH_WIDTH);

    logic [DATA_WIDTH-1:0]  r_mem [c_DEPTH];
    logic [DEPTH_WIDTH-1:0] r_wr_ptr;
    logic [DEPTH_WIDTH-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic [c_CNT_W-1:0]     w_count_nxt;
    logic                   r_avail;
    logic                   r_full;
    logic                   w_push_ok;

    // A pop in the same cycle frees the slot a full-FIFO push needs
    assign w_push_ok   = i_push && (!r_full || i_pop);
    assign o_push_drop = i_push && r_full && !i_pop;
    assign o_head      = r_mem[r_rd_ptr];
    assign o_avail     = r_avail;
    assign o_full      = r_full;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !i_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push_ok && i_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_avail  <= 1'b0;
            r_full   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_avail <= (w_count_nxt != '0);
            r_full  <= (w_count_nxt == c_CNT_W'(c_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/arashi_cache_arb.sv
`default_nettype none
// ============================================================================
// Module   : arashi_cache_arb
// Brief    : Per-thread FIFOs behind one shared read port (select or RR).
// Revision : 1.0 - initial release
// ============================================================================
module arashi_cache_arb
    import arashi_cache_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int THREAD_NUM_WIDTH = 2,
    parameter int DEPTH_WIDTH      = 2
) (
    input wire logic          clk,
    input wire logic          rst,
    arashi_cache_arb_if.slave bus
);
    localparam int c_THREAD_NUM = 1 << THREAD_NUM_WIDTH;

    logic [DATA_WIDTH-1:0]       w_head [c_THREAD_NUM];
    logic [c_THREAD_NUM-1:0]     w_avail;
    logic [c_THREAD_NUM-1:0]     w_full;
    logic [c_THREAD_NUM-1:0]     w_drop;
    logic [c_THREAD_NUM-1:0]     w_pop;
    rd_mode_t                    w_mode;
    logic [THREAD_NUM_WIDTH-1:0] w_rr_idx;
    logic [THREAD_NUM_WIDTH-1:0] w_rr_sel;
    logic                        w_rr_found;
    logic [THREAD_NUM_WIDTH-1:0] w_sel;
    logic                        w_pop_any;
    logic                        w_rd_err_set;

    logic [DATA_WIDTH-1:0]       r_data_out;
    logic                        r_out_valid;
    logic [THREAD_NUM_WIDTH-1:0] r_out_tid;
    logic [THREAD_NUM_WIDTH-1:0] r_rr_ptr;
    logic [c_THREAD_NUM-1:0]     r_overflow;
    logic                        r_rd_err;

    assign w_mode = rd_mode_t'(bus.mode);

    // First non-empty thread after the last round-robin grant
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_sel   = r_rr_ptr;
        w_rr_idx   = r_rr_ptr;
        for (int k = 1; k <= c_THREAD_NUM; k++) begin
            w_rr_idx = r_rr_ptr + THREAD_NUM_WIDTH'(k);
            if (!w_rr_found && w_avail[w_rr_idx]) begin
                w_rr_found = 1'b1;
                w_rr_sel   = w_rr_idx;
            end
        end
    end

    assign w_sel        = (w_mode == RD_RR) ? w_rr_sel : bus.toread;
    assign w_pop_any    = bus.rcache && w_avail[w_sel];
    assign w_rd_err_set = bus.rcache && (w_mode == RD_SELECT) && !w_avail[bus.toread];

    always_comb begin
        w_pop        = '0;
        w_pop[w_sel] = w_pop_any;
    end

    for (genvar gi = 0; gi < c_THREAD_NUM; gi++) begin : g_thread
        arashi_thread_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH_WIDTH(DEPTH_WIDTH)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .i_push     (bus.w_ena[gi]),
            .i_pop      (w_pop[gi]),
            .i_din      (bus.data_in[DATA_WIDTH*gi +: DATA_WIDTH]),
            .o_head     (w_head[gi]),
            .o_avail    (w_avail[gi]),
            .o_full     (w_full[gi]),
            .o_push_drop(w_drop[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_out_tid   <= '0;
            r_rr_ptr    <= '1;
            r_overflow  <= '0;
            r_rd_err    <= 1'b0;
        end else begin
            r_out_valid <= w_pop_any;
            if (w_pop_any) begin
                r_data_out <= w_head[w_sel];
                r_out_tid  <= w_sel;
            end
            if (w_pop_any && (w_mode == RD_RR)) begin
                r_rr_ptr <= w_sel;
            end
            // New errors override a simultaneous clear
            r_overflow <= (bus.clear_err ? '0 : r_overflow) | w_drop;
            r_rd_err   <= (bus.clear_err ? 1'b0 : r_rd_err) | w_rd_err_set;
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.out_valid = r_out_valid;
    assign bus.out_tid   = r_out_tid;
    assign bus.avail     = w_avail;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;
    assign bus.rd_err    = r_rd_err;

endmodule
`default_nettype wire

// File: doc/arashi_cache_arb.md
Name: arashi_cache_arb

Overview:
Per-thread buffering cache with a single shared read port. It is the successor to the existing per-thread cache: each thread gets a parametrised-depth FIFO instead of a single entry. The read port serves either an explicitly selected thread or a round-robin pick among non-empty threads. Per-thread fill and error flags are reported. It sits between the thread data producers and the single downstream consumer.

Parameters:
DATA_WIDTH, 32, width of one data word
THREAD_NUM_WIDTH, 2, log2 of thread count; THREAD_NUM = 1 << THREAD_NUM_WIDTH
DEPTH_WIDTH, 2, log2 of per-thread FIFO depth; DEPTH = 1 << DEPTH_WIDTH

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous, active-high reset
w_ena  input  THREAD_NUM  per-thread push strobe
data_in  input  DATA_WIDTH*THREAD_NUM  push data; thread i in bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
rcache  input  1  read request
mode  input  1  0 = select by toread, 1 = round-robin
toread  input  THREAD_NUM_WIDTH  thread to read when mode = 0
clear_err  input  1  clears the sticky error flags
data_out  output  DATA_WIDTH  popped word, registered
out_valid  output  1  data_out/out_tid valid this cycle
out_tid  output  THREAD_NUM_WIDTH  thread that data_out came from
avail  output  THREAD_NUM  thread FIFO non-empty
full  output  THREAD_NUM  thread FIFO holds DEPTH entries
overflow  output  THREAD_NUM  sticky: a push to a full FIFO was dropped
rd_err  output  1  sticky: mode-0 read of an empty thread

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. Sampled only at posedge clk.
- Reset values: all FIFOs empty; every output is 0, including data_out, out_tid, out_valid, avail, full, overflow and rd_err. The round-robin pointer is set to THREAD_NUM-1, so the first grant searches from thread 0.
- Reset mid-operation: all buffered contents are discarded. The read pipeline is flushed and out_valid = 0 in the cycle after reset.
- Push, per thread i, independently:
  - w_ena[i] with the FIFO not full: data is stored and the count increments.
  - w_ena[i] with the FIFO full: the data is dropped and overflow[i] is set.
  - Exception: if the same thread is popped in the same cycle, a push to a full FIFO is accepted.
- Read select, cycle N with rcache = 1:
  - mode 0: the selected thread is toread.
  - mode 1: the selected thread is the first thread with avail set, searching from rr_ptr+1 upward modulo THREAD_NUM.
- Pop happens in cycle N only if the selected thread's count, at the start of cycle N, is nonzero. There is no write-to-read bypass: a push in cycle N is not poppable in cycle N.
- Read latency is 1. In cycle N+1: out_valid = 1, data_out = head word, out_tid = the selected thread.
- No pop, because rcache = 0 or the selected thread is empty: out_valid = 0 in N+1, and data_out/out_tid hold their previous values.
- mode 0 read of an empty thread sets rd_err. mode 1 with no thread available sets nothing.
- The round-robin pointer updates to the granted thread only on a mode-1 pop. mode-0 pops do not move it.
- Simultaneous push and pop on one thread: the count is unchanged and FIFO order is preserved.
- avail and full are registered. They reflect the count after the cycle-N update, visible in N+1.
- clear_err zeroes overflow and rd_err. If a new error occurs in the same cycle as clear_err, the flag is set: set wins.
- Pointers are DEPTH_WIDTH bits wide and wrap naturally. The count is DEPTH_WIDTH+1 bits wide, range 0..DEPTH.

Decomposition:
- Package arashi_cache_pkg holds:
  - typedef enum logic {RD_SELECT = 1'b0, RD_RR = 1'b1} rd_mode_t;
  - a thread-id typedef and a count-width helper function.
- Sub-module arashi_thread_fifo: one instance per thread via generate. It owns the storage, pointers, count, avail and full for one thread. Its ports are push, pop, din, head, avail, full and push_drop.
- The top level holds the read select/arbiter, the output register and the error flags.

Test Plan (THREAD_NUM = 4, DEPTH = 4, DATA_WIDTH = 32):
- Reset then idle: all outputs 0, out_valid stays 0 with rcache = 1 in mode 1, rd_err = 0.
- Push 0x11, 0x12, 0x13 to thread 2, then mode-0 reads with toread = 2 on consecutive cycles: data_out 0x11, 0x12, 0x13 with out_tid = 2 on the cycles after each read. avail[2] falls in the cycle after the third pop.
- Push 5 words 0xA0..0xA4 to thread 1 back-to-back: full[1] = 1 after the 4th push, overflow[1] = 1, and reads return only 0xA0..0xA3. clear_err then drops overflow[1] to 0.
- Thread 1 full, push 0xB0 and pop in the same cycle: push accepted, full[1] stays 1, and 0xB0 is returned as the last read.
- One word in each of threads 0, 1 and 3, then mode 1 with rcache held 4 cycles: out_tid sequence 0, 1, 3, followed by out_valid = 0. rd_err stays 0.
- mode 0, toread = 3 with thread 3 empty and a simultaneous push of 0xC0 to thread 3: out_valid = 0, rd_err = 1. The next read returns 0xC0. Asserting rst mid-sequence empties all FIFOs and clears all flags.
